// File: rtl/csr_trap_sequencer.sv
// CSR trap/MRET sequencer: drives the CSR file's read and write ports to
// perform trap entry (mepc, mcause, mtval, mstatus) and MRET, then
// redirects the PC. Outputs are decoded from the registered state and latches.
module csr_trap_sequencer #(
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [1:0] MPP_VALUE   = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] csr_rd_data,
  output logic        busy,
  output logic        trap_ack,
  output logic [11:0] csr_rd_addr,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        wr_csr_n,
  output logic        mret_pulse,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;

  typedef enum logic [2:0] {
    StIdle,
    StTEpc,
    StTCause,
    StTTval,
    StTStatus,
    StTRedir,
    StMRead,
    StMRedir
  } state_e;

  state_e      state_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic [31:0] redirect_q;

  logic [31:0] trap_pc;
  logic [31:0] status_new;

  // Trap target from live mtvec; MODE 2/3 fall back to direct.
  always_comb begin
    trap_pc = {mtvec_in[31:2], 2'b00};
    if (VECTORED_EN && (mtvec_in[1:0] == 2'b01) && cause_q[31]) begin
      trap_pc = {mtvec_in[31:2], 2'b00} + {cause_q[29:0], 2'b00};
    end
  end

  // mstatus trap-entry update: MPIE <= MIE, MIE <= 0, MPP <= MPP_VALUE.
  always_comb begin
    status_new        = csr_rd_data;
    status_new[7]     = csr_rd_data[3];
    status_new[3]     = 1'b0;
    status_new[12:11] = MPP_VALUE;
  end

  // Sequencer state, request latches and the held redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cause_q    <= '0;
      epc_q      <= '0;
      tval_q     <= '0;
      redirect_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Trap has priority; a concurrent MRET is dropped and flushed upstream.
          if (trap_req) begin
            cause_q <= trap_cause;
            epc_q   <= trap_epc;
            tval_q  <= trap_tval;
            state_q <= StTEpc;
          end else if (mret_req) begin
            state_q <= StMRead;
          end
        end
        StTEpc:    state_q <= StTCause;
        StTCause:  state_q <= StTTval;
        StTTval:   state_q <= StTStatus;
        StTStatus: state_q <= StTRedir;
        StTRedir: begin
          redirect_q <= trap_pc;
          state_q    <= StIdle;
        end
        StMRead: begin
          redirect_q <= csr_rd_data;
          state_q    <= StMRedir;
        end
        StMRedir:  state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Port decode from state; unused address/data ports are held at zero.
  always_comb begin
    busy           = (state_q != StIdle);
    trap_ack       = 1'b0;
    csr_rd_addr    = '0;
    csr_wr_addr    = '0;
    csr_wr_data    = '0;
    wr_csr_n       = 1'b1;
    mret_pulse     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = redirect_q;
    unique case (state_q)
      StTEpc: begin
        trap_ack    = 1'b1;
        wr_csr_n    = 1'b0;
        csr_wr_addr = AddrMepc;
        csr_wr_data = epc_q;
      end
      StTCause: begin
        wr_csr_n    = 1'b0;
        csr_wr_addr = AddrMcause;
        csr_wr_data = cause_q;
      end
      StTTval: begin
        wr_csr_n    = 1'b0;
        csr_wr_addr = AddrMtval;
        csr_wr_data = tval_q;
      end
      StTStatus: begin
        wr_csr_n    = 1'b0;
        csr_rd_addr = AddrMstatus;
        csr_wr_addr = AddrMstatus;
        csr_wr_data = status_new;
      end
      StTRedir: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_pc;
      end
      StMRead: begin
        csr_rd_addr = AddrMepc;
        mret_pulse  = 1'b1;
      end
      StMRedir: begin
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: trap entry (direct/vectored),
// MRET, request priority, held requests and asynchronous reset mid-sequence.
module tb_csr_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic [31:0] mtvec_in;
  logic [31:0] csr_rd_data;

  logic        busy;
  logic        trap_ack;
  logic [11:0] csr_rd_addr;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        wr_csr_n;
  logic        mret_pulse;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Second instance with vectoring disabled, fed identical inputs.
  logic        d_busy;
  logic        d_trap_ack;
  logic [11:0] d_csr_rd_addr;
  logic [11:0] d_csr_wr_addr;
  logic [31:0] d_csr_wr_data;
  logic        d_wr_csr_n;
  logic        d_mret_pulse;
  logic        d_redirect_valid;
  logic [31:0] d_redirect_pc;

  logic [31:0] mstatus;
  logic [31:0] mepc;

  int checks = 0;
  int errors = 0;

  csr_trap_sequencer #(.VECTORED_EN(1'b1), .MPP_VALUE(2'b11)) u_dut (
    .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_tval(trap_tval), .mret_req(mret_req),
    .mtvec_in(mtvec_in), .csr_rd_data(csr_rd_data), .busy(busy), .trap_ack(trap_ack),
    .csr_rd_addr(csr_rd_addr), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .wr_csr_n(wr_csr_n), .mret_pulse(mret_pulse), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  csr_trap_sequencer #(.VECTORED_EN(1'b0), .MPP_VALUE(2'b11)) u_dut_direct (
    .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_tval(trap_tval), .mret_req(mret_req),
    .mtvec_in(mtvec_in), .csr_rd_data(csr_rd_data), .busy(d_busy),
    .trap_ack(d_trap_ack), .csr_rd_addr(d_csr_rd_addr), .csr_wr_addr(d_csr_wr_addr),
    .csr_wr_data(d_csr_wr_data), .wr_csr_n(d_wr_csr_n), .mret_pulse(d_mret_pulse),
    .redirect_valid(d_redirect_valid), .redirect_pc(d_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal CSR file read port model.
  always_comb begin
    csr_rd_data = 32'h0;
    case (csr_rd_addr)
      12'h300: csr_rd_data = mstatus;
      12'h341: csr_rd_data = mepc;
      default: csr_rd_data = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_ports(input string tag, input logic [31:0] exp_pc);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " ack"}, 32'(trap_ack), 32'd0);
    check({tag, " wr_n"}, 32'(wr_csr_n), 32'd1);
    check({tag, " rd_addr"}, 32'(csr_rd_addr), 32'd0);
    check({tag, " wr_addr"}, 32'(csr_wr_addr), 32'd0);
    check({tag, " wr_data"}, csr_wr_data, 32'd0);
    check({tag, " mret"}, 32'(mret_pulse), 32'd0);
    check({tag, " rv"}, 32'(redirect_valid), 32'd0);
    check({tag, " pc"}, redirect_pc, exp_pc);
  endtask

  // Issue one trap and check every cycle of the 5-cycle sequence.
  task automatic run_trap(input string tag, input logic [31:0] cause, input logic [31:0] epc,
                          input logic [31:0] tval, input logic [31:0] mtvec,
                          input logic [31:0] status, input logic [31:0] exp_status,
                          input logic [31:0] exp_pc, input logic [31:0] exp_pc_dir,
                          input bit hold);
    logic        e_wr_n;
    logic [11:0] e_wa;
    logic [31:0] e_wd;
    logic [11:0] e_ra;
    @(negedge clk);
    trap_req   = 1'b1;
    trap_cause = cause;
    trap_epc   = epc;
    trap_tval  = tval;
    mtvec_in   = mtvec;
    mstatus    = status;
    if (hold) mret_req = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) trap_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e_wr_n = 1'b1; e_wa = 12'h0; e_wd = 32'h0; e_ra = 12'h0;
      case (c)
        1: begin e_wr_n = 1'b0; e_wa = 12'h341; e_wd = epc; end
        2: begin e_wr_n = 1'b0; e_wa = 12'h342; e_wd = cause; end
        3: begin e_wr_n = 1'b0; e_wa = 12'h343; e_wd = tval; end
        4: begin e_wr_n = 1'b0; e_wa = 12'h300; e_wd = exp_status; e_ra = 12'h300; end
        default: ;
      endcase
      check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
      check($sformatf("%s c%0d ack", tag, c), 32'(trap_ack), 32'(c == 1));
      check($sformatf("%s c%0d wr_n", tag, c), 32'(wr_csr_n), 32'(e_wr_n));
      check($sformatf("%s c%0d wr_addr", tag, c), 32'(csr_wr_addr), 32'(e_wa));
      check($sformatf("%s c%0d wr_data", tag, c), csr_wr_data, e_wd);
      check($sformatf("%s c%0d rd_addr", tag, c), 32'(csr_rd_addr), 32'(e_ra));
      check($sformatf("%s c%0d mret", tag, c), 32'(mret_pulse), 32'd0);
      check($sformatf("%s c%0d rv", tag, c), 32'(redirect_valid), 32'(c == 5));
      check($sformatf("%s c%0d d_rv", tag, c), 32'(d_redirect_valid), 32'(c == 5));
      if (c == 5) begin
        check($sformatf("%s pc", tag), redirect_pc, exp_pc);
        check($sformatf("%s d_pc", tag), d_redirect_pc, exp_pc_dir);
      end
      if (c == 4) begin
        trap_req = 1'b0;
        mret_req = 1'b0;
      end
    end
    @(negedge clk);
    check_idle_ports({tag, " after"}, exp_pc);
    check({tag, " d_pc hold"}, d_redirect_pc, exp_pc_dir);
  endtask

  task automatic run_mret(input string tag, input logic [31:0] epc_val);
    @(negedge clk);
    mepc     = epc_val;
    mret_req = 1'b1;
    @(posedge clk);
    #1;
    mret_req = 1'b0;
    @(negedge clk);
    check({tag, " r busy"}, 32'(busy), 32'd1);
    check({tag, " r mret"}, 32'(mret_pulse), 32'd1);
    check({tag, " r rd_addr"}, 32'(csr_rd_addr), 32'h341);
    check({tag, " r wr_n"}, 32'(wr_csr_n), 32'd1);
    check({tag, " r rv"}, 32'(redirect_valid), 32'd0);
    check({tag, " r ack"}, 32'(trap_ack), 32'd0);
    @(negedge clk);
    check({tag, " x busy"}, 32'(busy), 32'd1);
    check({tag, " x mret"}, 32'(mret_pulse), 32'd0);
    check({tag, " x rv"}, 32'(redirect_valid), 32'd1);
    check({tag, " x pc"}, redirect_pc, epc_val);
    check({tag, " x wr_n"}, 32'(wr_csr_n), 32'd1);
    check({tag, " x rd_addr"}, 32'(csr_rd_addr), 32'd0);
    @(negedge clk);
    check_idle_ports({tag, " after"}, epc_val);
  endtask

  initial begin
    rst_n      = 1'b0;
    trap_req   = 1'b0;
    trap_cause = 32'h0;
    trap_epc   = 32'h0;
    trap_tval  = 32'h0;
    mret_req   = 1'b0;
    mtvec_in   = 32'h0;
    mstatus    = 32'h0;
    mepc       = 32'h0;

    #12;
    check_idle_ports("reset", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_ports("post reset", 32'h0);

    run_trap("direct", 32'h2, 32'h0001_0040, 32'hDEAD_BEEF, 32'h0002_0000,
             32'h8, 32'h1880, 32'h0002_0000, 32'h0002_0000, 1'b0);
    run_trap("vec irq", 32'h8000_0007, 32'h0001_0080, 32'h0, 32'h0002_0001,
             32'hA, 32'h1882, 32'h0002_001C, 32'h0002_0000, 1'b0);
    run_trap("vec exc", 32'h5, 32'h0001_00C0, 32'h1234_5678, 32'h0002_0001,
             32'h80, 32'h1800, 32'h0002_0000, 32'h0002_0000, 1'b0);
    run_trap("mode3", 32'h8000_000B, 32'h0001_0100, 32'h0, 32'h0003_0003,
             32'h0, 32'h1800, 32'h0003_0000, 32'h0003_0000, 1'b0);
    run_mret("mret", 32'h0001_0044);
    run_trap("both", 32'h8000_0003, 32'h0001_0200, 32'h55AA_55AA, 32'h0002_0001,
             32'h8, 32'h1880, 32'h0002_000C, 32'h0002_0000, 1'b1);
    @(negedge clk);
    check("both no mret", 32'(mret_pulse), 32'd0);
    check("both idle", 32'(busy), 32'd0);

    // Reset while in T_CAUSE must clear outputs immediately.
    @(negedge clk);
    trap_req   = 1'b1;
    trap_cause = 32'h4;
    trap_epc   = 32'h0001_0300;
    trap_tval  = 32'hCAFE_0000;
    mtvec_in   = 32'h0004_0000;
    @(posedge clk);
    #1;
    trap_req = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst wr_addr", 32'(csr_wr_addr), 32'h342);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_ports("mid reset", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_trap("after rst", 32'h4, 32'h0001_0300, 32'hCAFE_0000, 32'h0004_0000,
             32'h1808, 32'h1880, 32'h0004_0000, 32'h0004_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
